// File: rtl/polyveck_make_hint.sv
// Hint-vector builder: streams K*N (a0, a1) pairs, sets one hint bit per pair,
// counts the set bits and flags a count above OMEGA once the vector is complete.
module polyveck_make_hint #(
    parameter int K      = 6,
    parameter int N      = 256,
    parameter int GAMMA2 = 261888,
    parameter int OMEGA  = 55
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic signed [31:0]  a0,
    input  logic signed [31:0]  a1,
    output logic [K*N-1:0]      h_out,
    output logic [10:0]         hint_cnt,
    output logic                omega_fail,
    output logic                done,
    output logic                busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam int                IW     = $clog2(K*N);
    localparam logic signed [31:0] G_POS = 32'(GAMMA2);
    localparam logic signed [31:0] G_NEG = -G_POS;
    localparam logic [7:0]        LAST_C = 8'(N-1);
    localparam logic [2:0]        LAST_P = 3'(K-1);

    // a0 == -GAMMA2 is the one boundary where the high part decides the hint.
    function automatic logic make_hint(input logic signed [31:0] lo,
                                       input logic signed [31:0] hi);
        return (lo > G_POS) || (lo < G_NEG) || ((lo == G_NEG) && (hi != 32'sd0));
    endfunction

    logic [1:0]     r_state;
    logic [7:0]     r_coeff;
    logic [2:0]     r_poly;
    logic [K*N-1:0] r_h;
    logic [10:0]    r_cnt;
    logic           r_fail;

    logic           w_acc;
    logic           w_hint;
    logic           w_last;
    logic [10:0]    w_cnt_next;
    logic [IW-1:0]  w_idx;

    assign w_acc      = in_valid & in_ready;
    assign w_hint     = make_hint(a0, a1);
    assign w_last     = (r_poly == LAST_P) && (r_coeff == LAST_C);
    assign w_cnt_next = r_cnt + {10'd0, w_hint};
    assign w_idx      = IW'(r_poly) * IW'(N) + IW'(r_coeff);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_coeff <= '0;
            r_poly  <= '0;
            r_h     <= '0;
            r_cnt   <= '0;
            r_fail  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_h     <= '0;
                        r_cnt   <= '0;
                        r_fail  <= 1'b0;
                        r_coeff <= '0;
                        r_poly  <= '0;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (w_acc) begin
                        r_h[w_idx] <= w_hint;
                        r_cnt      <= w_cnt_next;
                        if (r_coeff == LAST_C) begin
                            r_coeff <= '0;
                            r_poly  <= r_poly + 3'd1;
                        end else begin
                            r_coeff <= r_coeff + 8'd1;
                        end
                        // Judge omega on the final count so the flag is ready in DONE.
                        if (w_last) begin
                            r_fail  <= (w_cnt_next > 11'(OMEGA));
                            r_state <= S_DONE;
                        end
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready   = (r_state == S_RUN);
    assign done       = (r_state == S_DONE);
    assign busy       = in_ready | done;
    assign h_out      = r_h;
    assign hint_cnt   = r_cnt;
    assign omega_fail = r_fail;

endmodule
